// File: rtl/fft_input_loader.sv
// Streams one 2048-sample complex frame into four 512-word RAM banks in natural
// order, then starts fft_control and holds off input until the FFT has finished.
module fft_input_loader #(
  parameter int DATA_W = 16
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic [DATA_W-1:0] iDATA_RE,
  input  logic [DATA_W-1:0] iDATA_IM,
  input  logic              iVALID,
  input  logic              iLAST,
  output logic              oREADY,
  input  logic              iFFT_RDY,
  output logic [3:0]        oWR_EN,
  output logic [8:0]        oWR_ADDR,
  output logic [DATA_W-1:0] oWR_RE,
  output logic [DATA_W-1:0] oWR_IM,
  output logic              oSTART,
  output logic              oBUSY,
  output logic              oERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_ACK,
    S_RUN
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [10:0] cnt;
  logic [1:0]  to_cnt;
  logic        take;
  logic        last_sample;
  logic        frame_err;
  logic        timeout;
  logic        ready_d;
  logic        start_d;
  logic        busy_d;

  // A sample offered in the cycle fft_control starts externally is dropped with the frame.
  assign take        = iVALID & oREADY & (state == S_LOAD) & iFFT_RDY;
  assign last_sample = (cnt == 11'd2047);
  assign frame_err   = take & (iLAST != last_sample);
  assign timeout     = (state == S_WAIT_ACK) & iFFT_RDY & (to_cnt == 2'd3);

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     state_next = iFFT_RDY ? S_LOAD : S_RUN;
      S_LOAD: begin
        if (!iFFT_RDY)                state_next = S_RUN;
        else if (take && last_sample) state_next = S_START;
      end
      S_START:    state_next = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!iFFT_RDY)            state_next = S_RUN;
        else if (to_cnt == 2'd3)  state_next = S_IDLE;
      end
      S_RUN:      if (iFFT_RDY) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Control outputs are registered; oSTART lands one cycle after the final RAM write.
  always_comb begin
    ready_d = (state_next == S_LOAD);
    start_d = (state == S_START);
    busy_d  = (state == S_START) || (state == S_WAIT_ACK) || (state == S_RUN);
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oREADY <= 1'b0;
      oSTART <= 1'b0;
      oBUSY  <= 1'b0;
      oERR   <= 1'b0;
      to_cnt <= '0;
    end else begin
      oREADY <= ready_d;
      oSTART <= start_d;
      oBUSY  <= busy_d;
      oERR   <= frame_err | timeout;
      to_cnt <= ((state == S_WAIT_ACK) && iFFT_RDY) ? to_cnt + 2'd1 : '0;
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      cnt      <= '0;
      oWR_EN   <= '0;
      oWR_ADDR <= '0;
      oWR_RE   <= '0;
      oWR_IM   <= '0;
    end else begin
      oWR_EN <= take ? (4'b0001 << cnt[10:9]) : '0;
      if (take) begin
        oWR_ADDR <= cnt[8:0];
        oWR_RE   <= iDATA_RE;
        oWR_IM   <= iDATA_IM;
      end
      if ((state == S_LOAD) && !iFFT_RDY) cnt <= '0;
      else if (take)                      cnt <= (iLAST || last_sample) ? '0 : cnt + 11'd1;
    end
  end

endmodule
